uart_tx: RTL and testbench

UART transmitter. It serialises one parallel word per handshake onto a single line in 8N1-style framing: start bit, data LSB-first, optional parity, then 1 or 2 stop bits.
It is the transmit-side counterpart of the UART receiver in the same serial subsystem and is driven by a host-side producer through a valid/ready handshake.
Bit timing comes from an internal baud counter; there is no separate baud-tick input.

---
 rtl/uart_tx.sv | 102 ++++++++++
 tb/tb_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: valid/ready UART transmitter with start, LSB-first data, optional parity and 1-2 stop bits.
// tx is registered from the current state, so the line trails the FSM by one clock.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUDRATE     = 9600,
    parameter int CLK_FREQ_MHZ = 125,
    parameter int BAUD_COUNT   = CLK_FREQ_MHZ * 1_000_000 / BAUDRATE,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int BW = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    assign tx_ready = state_q == IDLE;
    assign tx_busy  = state_q != IDLE;
    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign bit_end  = baud_q == BAUD_LAST;

    always_comb begin
        state_d  = state_q;
        baud_d   = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        tx_d     = (state_q == START)  ? 1'b0 :
                   (state_q == DATA)   ? shift_q[0] :
                   (state_q == PARITY) ? parity_q : 1'b1;
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d  = START;
                shift_d  = tx_data;
                parity_d = (^tx_data) ^ 1'(PARITY_ODD);
                bit_d    = '0;
                stop_d   = 1'b0;
            end
            START:  if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + CW'(1);
                if (bit_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: if (bit_end) begin
                if (STOP_BITS == 2 && !stop_q) stop_d = 1'b1;
                else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a line monitor decodes frames, tests compare against queued words.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [4:0] valid = '0;
    logic [4:0] ready_w, tx_w, busy_w, done_w;

    int n_checks = 0;
    int n_fail = 0;

    logic [9:0] exp_q[$];
    logic [9:0] rx_q[$];
    logic       mon_en = 1'b0;
    logic       mon_par = 1'b0;
    int         mon_sel = 0;
    logic       mon_line;
    logic [7:0] mon_d;
    logic       mon_p;

    always #5 clk = ~clk;
    assign mon_line = tx_w[mon_sel];

    uart_tx #(.BAUD_COUNT(4)) u0 (.clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.BAUD_COUNT(4), .PARITY_EN(1)) u1 (.clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.BAUD_COUNT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rstn(rstn), .tx_data(tx_data),
        .tx_valid(valid[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.BAUD_COUNT(4), .STOP_BITS(2)) u3 (.clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(valid[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));
    uart_tx u4 (.clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(valid[4]),
        .tx_ready(ready_w[4]), .tx(tx_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4]));

    // Line monitor for 4-cycle bits: sample mid-bit, push {stop, parity, data}.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rstn === 1'b1 && mon_line === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    mon_d[i] = mon_line;
                end
                mon_p = 1'b0;
                if (mon_par) begin
                    repeat (4) @(negedge clk);
                    mon_p = mon_line;
                end
                repeat (4) @(negedge clk);
                rx_q.push_back({mon_line, mon_p, mon_d});
            end
        end
    end

    task automatic send(input int inst, input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        valid[inst] = 1'b1;
        @(negedge clk);
        valid[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, output int k);
        k = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done_w[inst] === 1'b1) begin
                k = c;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({tx_w[i], ready_w[i], busy_w[i], done_w[i]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_hold inst%0d: {tx,ready,busy,done}=%b expected 1100", i,
                         {tx_w[i], ready_w[i], busy_w[i], done_w[i]});
            end
        end
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({tx_w[i], ready_w[i], busy_w[i], done_w[i]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_release inst%0d: {tx,ready,busy,done}=%b expected 1100", i,
                         {tx_w[i], ready_w[i], busy_w[i], done_w[i]});
            end
        end
    endtask

    task automatic test_single_frame;
        logic [9:0] fb;
        logic [9:0] got;
        logic       et;
        fb = {1'b1, 8'h41, 1'b0};
        mon_sel = 0;
        mon_par = 1'b0;
        mon_en = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 8'h41});
        send(0, 8'h41);
        n_checks++;
        if ({tx_w[0], ready_w[0], busy_w[0]} !== 3'b101) begin
            n_fail++;
            $display("FAIL accept_cycle: {tx,ready,busy}=%b expected 101", {tx_w[0], ready_w[0], busy_w[0]});
        end
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            et = (k <= 40) ? fb[(k-1)/4] : 1'b1;
            n_checks++;
            if (tx_w[0] !== et) begin
                n_fail++;
                $display("FAIL frame_tx k=%0d: tx=%b expected %b", k, tx_w[0], et);
            end
            n_checks++;
            if ({busy_w[0], ready_w[0], done_w[0]} !== {k < 40, k >= 40, k == 40}) begin
                n_fail++;
                $display("FAIL frame_ctl k=%0d: {busy,ready,done}=%b expected %b", k,
                         {busy_w[0], ready_w[0], done_w[0]}, {k < 40, k >= 40, k == 40});
            end
        end
        n_checks++;
        if (rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_rx: no frame decoded, expected %h", exp_q[0]);
            exp_q.delete();
        end else begin
            got = rx_q.pop_front();
            if (got !== exp_q[0]) begin
                n_fail++;
                $display("FAIL single_rx: got %h expected %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_parity;
        int         inst[3] = '{1, 1, 2};
        logic [7:0] dat[3] = '{8'h07, 8'h00, 8'h07};
        logic       par[3] = '{1'b1, 1'b0, 1'b0};
        logic [9:0] got;
        int         k;
        mon_par = 1'b1;
        for (int t = 0; t < 3; t++) begin
            mon_sel = inst[t];
            exp_q.push_back({1'b1, par[t], dat[t]});
            send(inst[t], dat[t]);
            wait_done(inst[t], k);
            n_checks++;
            if (k != 44) begin
                n_fail++;
                $display("FAIL parity_len case%0d: done after %0d cycles expected 44", t, k);
            end
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL parity_rx case%0d: no frame decoded, expected %h", t, exp_q[0]);
                exp_q.delete();
            end else begin
                got = rx_q.pop_front();
                if (got !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL parity_rx case%0d: got %h expected %h", t, got, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        mon_par = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0] got;
        int         k;
        mon_sel = 3;
        @(negedge clk);
        tx_data = 8'hA5;
        valid[3] = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 8'hA5});
        @(negedge clk);
        tx_data = 8'h3C;
        exp_q.push_back({1'b1, 1'b0, 8'h3C});
        n_checks++;
        if (ready_w[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_busy: ready=%b expected 0", ready_w[3]);
        end
        wait_done(3, k);
        n_checks++;
        if (k != 44 || ready_w[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done: cycles=%0d ready=%b expected 44 and 1", k, ready_w[3]);
        end
        @(negedge clk);
        n_checks++;
        if ({busy_w[3], done_w[3], tx_w[3]} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_restart: {busy,done,tx}=%b expected 101", {busy_w[3], done_w[3], tx_w[3]});
        end
        valid[3] = 1'b0;
        tx_data = 8'h00;
        @(negedge clk);
        n_checks++;
        if (tx_w[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_start_edge: tx=%b expected 0", tx_w[3]);
        end
        wait_done(3, k);
        n_checks++;
        if (k != 43) begin
            n_fail++;
            $display("FAIL b2b_second_done: cycles=%0d expected 43", k);
        end
        for (int f = 0; f < 2; f++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_rx%0d: rx entries=%0d expected entries=%0d", f, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front();
                if (got !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_rx%0d: got %h expected %h", f, got, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int lowcnt;
        int done_k;
        mon_en = 1'b0;
        send(0, 8'hFF);
        repeat (18) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({tx_w[0], ready_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL abort_async: {tx,ready,busy,done}=%b expected 1100",
                     {tx_w[0], ready_w[0], busy_w[0], done_w[0]});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        done_k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) done_k++;
        end
        n_checks++;
        if (done_k != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with done/busy, expected 0", done_k);
        end
        send(0, 8'hFF);
        lowcnt = 0;
        done_k = -1;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (tx_w[0] === 1'b0) lowcnt++;
            if (done_w[0] === 1'b1 && done_k < 0) done_k = k;
        end
        n_checks++;
        if (lowcnt != 4) begin
            n_fail++;
            $display("FAIL restart_start_len: low cycles=%0d expected 4", lowcnt);
        end
        n_checks++;
        if (done_k != 40) begin
            n_fail++;
            $display("FAIL restart_done: done at %0d expected 40", done_k);
        end
    endtask

    task automatic test_default_baud;
        int lowcnt;
        lowcnt = 0;
        send(4, 8'hFF);
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            if (tx_w[4] === 1'b0) lowcnt++;
            else if (lowcnt > 0) break;
        end
        n_checks++;
        if (lowcnt != 13020) begin
            n_fail++;
            $display("FAIL default_start_len: low cycles=%0d expected 13020", lowcnt);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_parity;
        test_back_to_back;
        test_reset_mid_frame;
        test_default_baud;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
